fetch_unit: RTL and testbench

- Instruction-fetch stage that directly feeds the decode Controller: holds the PC and fetches one instruction at a time from instruction memory over a req/rvalid handshake.
- Presents opcode/funct (plus the full instruction) to decode.
- Computes the next PC from the sequential, branch, jump and jump-register outcomes returned when the instruction retires.
- Keeps a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/next_pc_calc.sv | 45 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/funct constants and fetch state enum shared with decode
package cpu_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // primary opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes, instr[5:0]
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   // instruction addresses must land on a 4-byte boundary
   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - redirect target selection and jump-register alignment check
module next_pc_calc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [25:0]       instr_index,
   input  logic              br_taken,
   input  logic              jump,
   input  logic              jump_reg,
   input  logic [ADDR_W-1:0] rs_data,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] next_pc,
   output logic              misaligned
);

   logic [ADDR_W-1:0] br_offset;
   logic [ADDR_W-1:0] jump_target;

   // all arithmetic wraps naturally at the top of the address space
   assign pc_plus4    = pc + ADDR_W'(4);
   // imm16 is the low half of the index field; word offset, sign-extended
   assign br_offset   = {{(ADDR_W-18){instr_index[15]}}, instr_index[15:0], 2'b00};
   assign jump_target = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00};

   // priority: jump_reg > jump > br_taken > sequential; a bad jr target keeps pc
   always_comb begin
      misaligned = 1'b0;
      next_pc    = pc_plus4;
      if (jump_reg) begin
         if (!is_word_aligned(rs_data[1:0])) begin
            misaligned = 1'b1;
            next_pc    = pc;
         end else begin
            next_pc = rs_data;
         end
      end else if (jump) begin
         next_pc = jump_target;
      end else if (br_taken) begin
         next_pc = pc_plus4 + br_offset;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage with pc and retire counter
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [5:0]        funct,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   input  logic              br_taken,
   input  logic              jump,
   input  logic              jump_reg,
   input  logic [31:0]       rs_data,
   output logic              misaligned_err,
   output logic [31:0]       instret
);

   fetch_state_e      state_q;
   fetch_state_e      state_d;
   logic              req_en_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       instret_q;
   logic              err_q;
   logic              fetch_fire;
   logic              retire;
   logic [ADDR_W-1:0] next_pc;
   logic              misaligned;

   next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc_calc (
      .pc          (pc_q),
      .instr_index (instr_q[25:0]),
      .br_taken    (br_taken),
      .jump        (jump),
      .jump_reg    (jump_reg),
      .rs_data     (rs_data[ADDR_W-1:0]),
      .pc_plus4    (pc_plus4),
      .next_pc     (next_pc),
      .misaligned  (misaligned)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and handshake outputs; req is held off until the first edge after reset
   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      fetch_fire  = 1'b0;
      retire      = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req   = req_en_q;
            fetch_fire = req_en_q & imem_rvalid;
            if (fetch_fire) begin
               state_d = VALID;
            end
         end
         VALID: begin
            instr_valid = 1'b1;
            retire      = instr_ready;
            if (retire) begin
               state_d = misaligned ? HALT : FETCH;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // datapath: instruction capture, pc update, retire count, sticky alignment error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_en_q  <= 1'b0;
         instr_q   <= 32'h0;
         pc_q      <= RESET_PC;
         instret_q <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         req_en_q <= 1'b1;
         if (fetch_fire) begin
            instr_q <= imem_rdata;
         end
         if (retire) begin
            instret_q <= instret_q + 32'd1;
            pc_q      <= next_pc;
            if (misaligned) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign instr          = instr_q;
   assign opcode         = instr_valid ? instr_q[31:26] : 6'd0;
   assign funct          = instr_valid ? instr_q[5:0]   : 6'd0;
   assign misaligned_err = err_q;
   assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        br_taken;
   logic        jump;
   logic        jump_reg;
   logic [31:0] rs_data;
   logic        misaligned_err;
   logic [31:0] instret;

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .opcode         (opcode),
      .funct          (funct),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .br_taken       (br_taken),
      .jump           (jump),
      .jump_reg       (jump_reg),
      .rs_data        (rs_data),
      .misaligned_err (misaligned_err),
      .instret        (instret)
   );

   localparam logic [31:0] W_ADDI = 32'h2008_0005;
   localparam logic [31:0] W_NOP  = 32'h0000_0000;
   localparam logic [31:0] W_BEQ  = 32'h1000_FFFC;
   localparam logic [31:0] W_JR   = 32'h03E0_0008;
   localparam logic [31:0] W_J    = 32'h0800_0040;
   localparam logic [31:0] W_JALR = 32'h0000_F809;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [31:0] instr;
      logic [31:0] instret;
   } dec_t;

   logic [31:0] exp_addr_q[$];
   dec_t        exp_dec_q[$];
   logic [31:0] exp_ret_q[$];

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout/missing required=event", nm);
   endtask

   // monitor: pops expectations whenever the DUT presents a request, an instruction or a retire
   logic [31:0] cur_addr;
   dec_t        cur_dec;
   logic        prev_req;
   logic        prev_valid;
   logic        ret_pend;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req   = 1'b0;
         prev_valid = 1'b0;
         ret_pend   = 1'b0;
      end else begin
         if (ret_pend) begin
            if (exp_ret_q.size() > 0) chk("instret_after_retire", instret, exp_ret_q.pop_front());
            else fail_now("unexpected_retire");
            ret_pend = 1'b0;
         end
         if (imem_req && !prev_req) begin
            if (exp_addr_q.size() > 0) begin
               cur_addr = exp_addr_q.pop_front();
               chk("fetch_addr", imem_addr, cur_addr);
            end else begin
               fail_now("unexpected_fetch_req");
            end
         end else if (imem_req) begin
            chk("addr_stable", imem_addr, cur_addr);
         end
         if (instr_valid && !prev_valid) begin
            if (exp_dec_q.size() > 0) begin
               cur_dec = exp_dec_q.pop_front();
               chk("dec_pc", pc, cur_dec.pc);
               chk("dec_pc_plus4", pc_plus4, cur_dec.pc_plus4);
               chk("dec_opcode", {26'd0, opcode}, {26'd0, cur_dec.opcode});
               chk("dec_funct", {26'd0, funct}, {26'd0, cur_dec.funct});
               chk("dec_instr", instr, cur_dec.instr);
               chk("dec_instret", instret, cur_dec.instret);
            end else begin
               fail_now("unexpected_instr_valid");
            end
         end else if (instr_valid) begin
            chk("hold_pc", pc, cur_dec.pc);
            chk("hold_opcode", {26'd0, opcode}, {26'd0, cur_dec.opcode});
            chk("hold_funct", {26'd0, funct}, {26'd0, cur_dec.funct});
            chk("hold_instret", instret, cur_dec.instret);
         end
         if (!instr_valid) chk("opfn_zero_when_invalid", {20'd0, opcode, funct}, 32'd0);
         if (instr_valid && instr_ready) ret_pend = 1'b1;
         prev_req   = imem_req;
         prev_valid = instr_valid;
      end
   end

   task automatic serve_fetch(input logic [31:0] word, input int lat);
      int n = 0;
      while (!imem_req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!imem_req) begin
         fail_now("fetch_req_wait");
         return;
      end
      repeat (lat) begin
         @(posedge clk); #1;
      end
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
   endtask

   // hold cycles drive noisy redirects with instr_ready low; they must be ignored
   task automatic retire_instr(input int hold, input logic br, input logic j, input logic jr,
                               input logic [31:0] rs);
      int n = 0;
      while (!instr_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!instr_valid) begin
         fail_now("instr_valid_wait");
         return;
      end
      repeat (hold) begin
         br_taken = 1'b1; jump = 1'b1; jump_reg = 1'b1; rs_data = 32'h0000_0003;
         imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
         @(posedge clk); #1;
      end
      imem_rvalid = 1'b0;
      br_taken = br; jump = j; jump_reg = jr; rs_data = rs; instr_ready = 1'b1;
      @(posedge clk); #1;
      instr_ready = 1'b0; br_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0; rs_data = 32'h0;
   endtask

   task automatic push_exp(input logic [31:0] addr, input logic [31:0] word, input logic [31:0] ret_before);
      dec_t d;
      d.pc       = addr;
      d.pc_plus4 = addr + 32'd4;
      d.opcode   = word[31:26];
      d.funct    = word[5:0];
      d.instr    = word;
      d.instret  = ret_before;
      exp_dec_q.push_back(d);
      exp_ret_q.push_back(ret_before + 32'd1);
   endtask

   task automatic fetch_exec(input logic [31:0] addr, input logic [31:0] word, input int lat,
                             input logic [31:0] ret_before, input int hold, input bit addr_pushed,
                             input logic br, input logic j, input logic jr, input logic [31:0] rs);
      if (!addr_pushed) exp_addr_q.push_back(addr);
      push_exp(addr, word, ret_before);
      serve_fetch(word, lat);
      retire_instr(hold, br, j, jr, rs);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      br_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0; rs_data = 32'h0;
      #2;
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instret", instret, 32'h0);
      chk("rst_err", {31'd0, misaligned_err}, 32'd0);
      #10;
      rst_n = 1'b1;
      #1;
      chk("req_low_before_first_edge", {31'd0, imem_req}, 32'd0);

      // sequential addi stream, latencies 3 / 0 / 1
      fetch_exec(32'h0000_0000, W_ADDI, 3, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      fetch_exec(32'h0000_0004, W_ADDI, 0, 32'd1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      fetch_exec(32'h0000_0008, W_ADDI, 1, 32'd2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      fetch_exec(32'h0000_000C, W_NOP,  2, 32'd3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      // beq at 0x10, imm -4, held 5 cycles with ignored redirects -> 0x04
      fetch_exec(32'h0000_0010, W_BEQ,  1, 32'd4, 5, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      // jr at 0x04 to 0x4000_0000
      fetch_exec(32'h0000_0004, W_JR,   0, 32'd5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0000);
      // j index 0x40 -> 0x4000_0100
      fetch_exec(32'h4000_0000, W_J,    2, 32'd6, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      // all redirects together, jump_reg wins -> 0x80
      fetch_exec(32'h4000_0100, W_JALR, 1, 32'd7, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);

      // reset during the fetch at 0x80 with responses arriving
      exp_addr_q.push_back(32'h0000_0080);
      @(posedge clk); #1;
      imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midfetch_rst_req_drop", {31'd0, imem_req}, 32'd0);
      chk("midfetch_rst_pc", pc, 32'h0);
      chk("midfetch_rst_instret", instret, 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         imem_rvalid = ~imem_rvalid;
      end
      chk("rst_discard_instr", instr, 32'h0);
      @(negedge clk); #2;
      imem_rvalid = 1'b0;
      exp_addr_q.push_back(32'h0000_0000);
      rst_n = 1'b1;
      #1;
      chk("rerelease_req_low", {31'd0, imem_req}, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("post_rst_no_valid", {31'd0, instr_valid}, 32'd0);
         chk("post_rst_req", {31'd0, imem_req}, 32'd1);
         chk("post_rst_addr", imem_addr, 32'h0);
      end

      // jr to the top word, then pc_plus4 and instret both wrap
      fetch_exec(32'h0000_0000, W_JR, 0, 32'd0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      exp_addr_q.push_back(32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC, W_NOP, 32'hFFFF_FFFF);
      @(negedge clk); #1;
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      serve_fetch(W_NOP, 2);
      retire_instr(0, 1'b0, 1'b0, 1'b0, 32'h0);
      fetch_exec(32'h0000_0000, W_JR, 1, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020);

      // misaligned jr at 0x20 halts
      fetch_exec(32'h0000_0020, W_JR, 0, 32'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
      chk("halt_err", {31'd0, misaligned_err}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, 32'h0000_0020);
      imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      chk("halt_instr_kept", instr, W_JR);
      repeat (4) begin
         @(posedge clk); #1;
         chk("halt_req_stays_low", {31'd0, imem_req}, 32'd0);
         chk("halt_err_sticky", {31'd0, misaligned_err}, 32'd1);
      end
      chk("addr_queue_drained", exp_addr_q.size(), 32'd0);
      chk("dec_queue_drained", exp_dec_q.size(), 32'd0);
      chk("ret_queue_drained", exp_ret_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
